// File: rtl/uart_prog_loader.sv
// UART boot loader: packs 8N1 bytes into little-endian 32-bit words and issues
// auto-incrementing word writes. Define UPG_ECHO_EN to echo received bytes on upg_tx_o.
module uart_prog_loader #(
    parameter int unsigned CLKS_PER_BIT = 78,
    parameter int unsigned IDLE_BITS    = 4096,
    parameter int unsigned ADDR_W       = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              upg_wen_o,
    output logic [ADDR_W-1:0] upg_adr_o,
    output logic [31:0]       upg_dat_o,
    output logic              upg_done_o,
    output logic              upg_tx_o,
    output logic              frame_err_o
);

    localparam int unsigned TMR_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDL_W = $clog2(IDLE_BITS + 1);
    localparam logic [TMR_W-1:0]  TMR_HALF = TMR_W'(CLKS_PER_BIT / 2);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [IDL_W-1:0]  IDL_LAST = IDL_W'(IDLE_BITS - 1);
    localparam logic [ADDR_W-1:0] ADR_MAX  = '1;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    logic              rx_meta_q, rx_meta_d;
    logic              rxs_q, rxs_d;
    logic              rxs_prev_q, rxs_prev_d;
    rx_state_e         state_q, state_d;
    logic [TMR_W-1:0]  bit_tmr_q, bit_tmr_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        byte_q, byte_d;
    logic [23:0]       lanes_q, lanes_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic              wen_q, wen_d;
    logic [31:0]       dat_q, dat_d;
    logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
    logic              done_q, done_d;
    logic              ferr_q, ferr_d;
    logic              got_byte_q, got_byte_d;
    logic [TMR_W-1:0]  idle_cyc_q, idle_cyc_d;
    logic [IDL_W-1:0]  idle_bits_q, idle_bits_d;
    logic              byte_vld_c;
    logic              rx_fall_c;
    logic              idle_run_c;

    assign rx_fall_c  = rxs_prev_q & ~rxs_q;
    assign idle_run_c = got_byte_q & ~done_q & (state_q == RX_IDLE);

    // Receiver: synchroniser, start-bit qualification, mid-bit sampling.
    always_comb begin
        rx_meta_d  = rx;
        rxs_d      = rx_meta_q;
        rxs_prev_d = rxs_q;
        state_d    = state_q;
        bit_tmr_d  = bit_tmr_q + TMR_W'(1);
        bit_idx_d  = bit_idx_q;
        byte_d     = byte_q;
        ferr_d     = ferr_q;
        byte_vld_c = 1'b0;
        case (state_q)
            RX_IDLE: begin
                bit_tmr_d = '0;
                bit_idx_d = '0;
                if (rx_fall_c) state_d = RX_START;
            end
            RX_START: begin
                if (bit_tmr_q == TMR_HALF) begin
                    bit_tmr_d = '0;
                    state_d   = rxs_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (bit_tmr_q == TMR_LAST) begin
                    bit_tmr_d = '0;
                    byte_d    = {rxs_q, byte_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (bit_tmr_q == TMR_LAST) begin
                    state_d = RX_IDLE;
                    if (rxs_q) byte_vld_c = 1'b1;
                    else       ferr_d     = 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
        // Once loading is complete the line is ignored entirely.
        if (done_q) begin
            state_d    = RX_IDLE;
            byte_vld_c = 1'b0;
            ferr_d     = ferr_q;
        end
    end

    // Word assembly, write strobe, address counter and idle timeout.
    always_comb begin
        lanes_d     = lanes_q;
        byte_cnt_d  = byte_cnt_q;
        wen_d       = 1'b0;
        dat_d       = dat_q;
        word_cnt_d  = word_cnt_q;
        done_d      = done_q;
        got_byte_d  = got_byte_q | byte_vld_c;
        idle_cyc_d  = idle_cyc_q;
        idle_bits_d = idle_bits_q;

        if (byte_vld_c) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            case (byte_cnt_q)
                2'd0:    lanes_d[7:0]   = byte_q;
                2'd1:    lanes_d[15:8]  = byte_q;
                2'd2:    lanes_d[23:16] = byte_q;
                default: begin
                    wen_d = 1'b1;
                    dat_d = {byte_q, lanes_q};
                end
            endcase
        end

        if (wen_q) begin
            if (word_cnt_q == ADR_MAX) done_d = 1'b1;
            else                       word_cnt_d = word_cnt_q + ADDR_W'(1);
        end

        // A falling edge always restarts the idle measurement, even on a timeout cycle.
        if (rx_fall_c) begin
            idle_cyc_d  = '0;
            idle_bits_d = '0;
        end else if (idle_run_c) begin
            if (idle_cyc_q == TMR_LAST) begin
                idle_cyc_d = '0;
                if (idle_bits_q == IDL_LAST) begin
                    done_d     = 1'b1;
                    byte_cnt_d = '0;
                end else begin
                    idle_bits_d = idle_bits_q + IDL_W'(1);
                end
            end else begin
                idle_cyc_d = idle_cyc_q + TMR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q   <= 1'b1;
            rxs_q       <= 1'b1;
            rxs_prev_q  <= 1'b1;
            state_q     <= RX_IDLE;
            bit_tmr_q   <= '0;
            bit_idx_q   <= '0;
            byte_q      <= '0;
            lanes_q     <= '0;
            byte_cnt_q  <= '0;
            wen_q       <= 1'b0;
            dat_q       <= '0;
            word_cnt_q  <= '0;
            done_q      <= 1'b0;
            ferr_q      <= 1'b0;
            got_byte_q  <= 1'b0;
            idle_cyc_q  <= '0;
            idle_bits_q <= '0;
        end else begin
            rx_meta_q   <= rx_meta_d;
            rxs_q       <= rxs_d;
            rxs_prev_q  <= rxs_prev_d;
            state_q     <= state_d;
            bit_tmr_q   <= bit_tmr_d;
            bit_idx_q   <= bit_idx_d;
            byte_q      <= byte_d;
            lanes_q     <= lanes_d;
            byte_cnt_q  <= byte_cnt_d;
            wen_q       <= wen_d;
            dat_q       <= dat_d;
            word_cnt_q  <= word_cnt_d;
            done_q      <= done_d;
            ferr_q      <= ferr_d;
            got_byte_q  <= got_byte_d;
            idle_cyc_q  <= idle_cyc_d;
            idle_bits_q <= idle_bits_d;
        end
    end

    assign upg_wen_o   = wen_q;
    assign upg_adr_o   = word_cnt_q;
    assign upg_dat_o   = dat_q;
    assign upg_done_o  = done_q;
    assign frame_err_o = ferr_q;

`ifdef UPG_ECHO_EN
    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    tx_state_e        tx_state_q, tx_state_d;
    logic [TMR_W-1:0] tx_tmr_q, tx_tmr_d;
    logic [2:0]       tx_idx_q, tx_idx_d;
    logic [7:0]       tx_sh_q, tx_sh_d;
    logic             tx_q, tx_d;
    logic [7:0]       ebuf_q, ebuf_d;
    logic             ebuf_full_q, ebuf_full_d;

    // One-entry echo buffer feeding an 8N1 transmitter; overflow bytes skip the echo.
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_tmr_d    = tx_tmr_q + TMR_W'(1);
        tx_idx_d    = tx_idx_q;
        tx_sh_d     = tx_sh_q;
        tx_d        = tx_q;
        ebuf_d      = ebuf_q;
        ebuf_full_d = ebuf_full_q;
        if (byte_vld_c && !ebuf_full_q) begin
            ebuf_d      = byte_q;
            ebuf_full_d = 1'b1;
        end
        case (tx_state_q)
            TX_IDLE: begin
                tx_d     = 1'b1;
                tx_tmr_d = '0;
                if (ebuf_full_q) begin
                    tx_sh_d     = ebuf_q;
                    ebuf_full_d = 1'b0;
                    tx_d        = 1'b0;
                    tx_state_d  = TX_START;
                end
            end
            TX_START: begin
                if (tx_tmr_q == TMR_LAST) begin
                    tx_tmr_d   = '0;
                    tx_idx_d   = '0;
                    tx_d       = tx_sh_q[0];
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_tmr_q == TMR_LAST) begin
                    tx_tmr_d = '0;
                    if (tx_idx_q == 3'd7) begin
                        tx_d       = 1'b1;
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_d     = tx_sh_q[1];
                        tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                        tx_idx_d = tx_idx_q + 3'd1;
                    end
                end
            end
            TX_STOP: begin
                if (tx_tmr_q == TMR_LAST) tx_state_d = TX_IDLE;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q  <= TX_IDLE;
            tx_tmr_q    <= '0;
            tx_idx_q    <= '0;
            tx_sh_q     <= '0;
            tx_q        <= 1'b1;
            ebuf_q      <= '0;
            ebuf_full_q <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_tmr_q    <= tx_tmr_d;
            tx_idx_q    <= tx_idx_d;
            tx_sh_q     <= tx_sh_d;
            tx_q        <= tx_d;
            ebuf_q      <= ebuf_d;
            ebuf_full_q <= ebuf_full_d;
        end
    end

    assign upg_tx_o = tx_q;
`else
    assign upg_tx_o = 1'b1;
`endif

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- UART boot loader that sits directly upstream of the CPU's instruction and data memories.
- Receives a raw byte stream on `rx` and assembles each group of 4 bytes into a little-endian 32-bit word.
- Emits one write strobe per word with an auto-incrementing 15-bit word address. `upg_adr_o[14]`=0 targets instruction memory; 1 targets data memory.
- Signals completion so the core can be released from reset.

Parameters:
- CLKS_PER_BIT, 78, `clk` cycles per UART bit (10 MHz / 128000 baud); minimum 4.
- IDLE_BITS, 4096, bit periods of line idle after the first received byte that end the load.
- ADDR_W, 15, width of the word address output; the top bit is the memory select.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- rx  in  1  UART receive line, idle high, asynchronous to `clk`.
- upg_wen_o  out  1  one-cycle word write strobe.
- upg_adr_o  out  ADDR_W  word address; valid while `upg_wen_o`=1.
- upg_dat_o  out  32  word data {b3,b2,b1,b0}; valid while `upg_wen_o`=1.
- upg_done_o  out  1  load complete; sticky until reset.
- upg_tx_o  out  1  UART transmit line (see optional feature).
- frame_err_o  out  1  sticky; set on any stop bit sampled low.

Behaviour:
- Reset (`rst`=0, async) values:
  - `upg_wen_o`=0, `upg_adr_o`=0, `upg_dat_o`=0, `upg_done_o`=0, `frame_err_o`=0, `upg_tx_o`=1.
  - Byte counter=0, word counter=0, receiver in IDLE.
  - Asserting reset mid-byte or mid-word discards all partial data.
- `rx` passes through a 2-flop synchroniser; the synchronised signal is `rxs`, which adds 2 cycles of latency.
- Receiver FSM:
  - IDLE: on `rxs` 1->0, go to START with the bit timer cleared.
  - START: at timer = CLKS_PER_BIT/2 (integer divide), sample `rxs`. If 1, treat as a glitch and return to IDLE. If 0, go to DATA.
  - DATA: sample once every CLKS_PER_BIT cycles; 8 bits, LSB first, shifted into `byte_r`. After bit 7, go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - 1: byte valid; pulse internal `byte_vld` for 1 cycle.
    - 0: set `frame_err_o` and discard the byte; the byte counter is unchanged.
    - Either way, return to IDLE on the same cycle, so back-to-back frames are accepted.
- Word assembler:
  - `byte_vld` stores `byte_r` into lane `byte_cnt` and increments `byte_cnt` (2 bits, wraps).
  - On the 4th byte (`byte_cnt`=3), the next cycle has `upg_wen_o`=1 for exactly 1 cycle, with `upg_adr_o`=word counter and `upg_dat_o`=assembled word.
  - The word counter increments on the same edge that clears `upg_wen_o`.
  - Latency: stop-bit sample to `upg_wen_o` high = 1 cycle.
- Completion:
  - Full: writing the word at address 2^ADDR_W-1 sets `upg_done_o` in the same cycle `upg_wen_o` drops. The word counter does not wrap.
  - Timeout: the idle counter runs only once at least one valid byte has been received. It is cleared on every `rxs` falling edge. It counts bit periods while the FSM is in IDLE. When it reaches IDLE_BITS, `upg_done_o`=1 and any partial word (`byte_cnt`!=0) is discarded with no write.
  - After done, `rx` is ignored and no further `upg_wen_o` pulses occur until reset.
- A line held low after done is ignored; a line held low before done re-enters START and fails the stop check.
- Simultaneous events: if a timeout and a `rxs` falling edge occur in the same cycle, the falling edge wins and the timer clears.

Optional Feature:
- Macro: `UPG_ECHO_EN`.
- Defined:
  - Each valid received byte is loaded into a 1-entry holding buffer.
  - An 8N1 transmitter at CLKS_PER_BIT sends the buffer on `upg_tx_o`; the start bit begins within 2 cycles of `byte_vld` if the transmitter is idle.
  - If the buffer is already full when a new byte arrives, the new byte is dropped from the echo only; loading still proceeds.
  - The transmitter finishes a frame in progress after done.
- Not defined: `upg_tx_o` is constant 1 and no transmitter logic exists.

Test Plan:
- CLKS_PER_BIT=4, IDLE_BITS=16. Send bytes 0x78,0x56,0x34,0x12 then 0xEF,0xBE,0xAD,0xDE -> `upg_wen_o` pulses twice, each 1 cycle: (adr 0x0000, dat 0x12345678) and (adr 0x0001, dat 0xDEADBEEF).
- Send 0x11,0x22 then leave the line idle for 16+ bit periods -> `upg_done_o`=1, no `upg_wen_o` pulse. Further bytes on `rx` -> still no writes.
- Send a frame with stop bit 0 (data 0xAA), then 4 good bytes 0x01..0x04 -> `frame_err_o`=1, one write of 0x04030201 at adr 0.
- Drive a 1-cycle low glitch on `rx` -> no byte, no error, FSM back to IDLE. Then a valid word -> write at adr 0.
- ADDR_W=3: stream 8 words -> last write at adr 7 and `upg_done_o`=1 on the following cycle. A 9th word -> ignored.
- Assert `rst`=0 after 2 bytes, release, then send 4 bytes 0xA0..0xA3 -> write at adr 0 with dat 0xA3A2A1A0, all outputs at reset values during reset. With `UPG_ECHO_EN`, `upg_tx_o` replays each byte bit-exact.
